// File: rtl/ad100_pkg.sv
// ad100_pkg: definitions shared by the ad100 UART transmitter files.
//   - tx_state_t : 2-bit serial FSM state encoding (IDLE/START/DATA/STOP)
//   - REG_*      : word offsets of the registers inside the two-word window
//   - STAT_*     : bit positions of the fields in the STATUS register
package ad100_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  localparam int REG_DATA   = 0;
  localparam int REG_STATUS = 1;

  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_COUNT_LSB = 8;
  localparam int STAT_COUNT_W   = 8;

endpackage

// File: rtl/ad100_uart_tx_if.sv
// ad100_uart_tx_if: CPU data-port signals seen by the UART register window.
//   addr_2         : word address from the CPU
//   write_2        : store data from the CPU
//   write_enable_N : byte-lane store strobes (lane N-1)
//   sel            : device claims the current address (combinational)
//   read_data      : device read value, 0 when sel is low (combinational)
// master = CPU side, slave = device side.
interface ad100_uart_tx_if;

  logic [29:0] addr_2;
  logic [31:0] write_2;
  logic        write_enable_1;
  logic        write_enable_2;
  logic        write_enable_3;
  logic        write_enable_4;
  logic        sel;
  logic [31:0] read_data;

  modport master (
    output addr_2, write_2,
    output write_enable_1, write_enable_2, write_enable_3, write_enable_4,
    input  sel, read_data
  );

  modport slave (
    input  addr_2, write_2,
    input  write_enable_1, write_enable_2, write_enable_3, write_enable_4,
    output sel, read_data
  );

endinterface

// File: rtl/ad100_byte_fifo.sv
// ad100_byte_fifo: synchronous 8-bit FIFO.
//   clk, reset : clock and synchronous active-high reset
//   push       : write push_data (accepted when not full, or when popping
//                in the same cycle)
//   pop        : remove the head entry (ignored when empty)
//   pop_data   : current head entry, valid while not empty
//   full/empty : occupancy flags
//   count      : number of stored entries, 0..DEPTH
module ad100_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop,
  output logic [7:0]                 pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

  // When full, a simultaneous pop frees the slot being written: wr_ptr equals
  // rd_ptr then, and the head is read out before the edge overwrites it.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  // The head must be available in the same cycle it is popped into the
  // shift register, so the storage is read asynchronously.
  assign pop_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

endmodule

// File: rtl/ad100_uart_tx.sv
// ad100_uart_tx: memory-mapped 8N1 UART transmitter.
//   clk, reset : clock and synchronous active-high reset
//   bus        : CPU data port (slave side); DATA at BASE_ADDR (write pushes a
//                byte), STATUS at BASE_ADDR+1 (full/empty/busy/overflow/count,
//                write bit 3 clears overflow). Reads are combinational and have
//                no side effects.
//   tx         : registered serial output, idle high
module ad100_uart_tx #(
  parameter logic [29:0] BASE_ADDR    = 30'h3FFF_FC00,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  ad100_uart_tx_if.slave         bus,
  output logic                   tx
);

  import ad100_pkg::*;

  localparam int          BAUD_W      = $clog2(CLKS_PER_BIT);
  localparam int          CNT_W       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [29:0] DATA_ADDR   = BASE_ADDR + 30'(REG_DATA);
  localparam logic [29:0] STATUS_ADDR = BASE_ADDR + 30'(REG_STATUS);

  tx_state_t         state_reg, state_next;
  logic [BAUD_W-1:0] baud_reg, baud_next;
  logic [2:0]        bit_idx_reg, bit_idx_next;
  logic [7:0]        shift_reg, shift_next;
  logic              tx_reg, tx_next;
  logic              overflow_reg;

  logic              fifo_push;
  logic              fifo_pop;
  logic [7:0]        fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  logic              hit_data;
  logic              hit_status;
  logic              overflow_set;
  logic              overflow_clr;
  logic [31:0]       status_word;

  // Upper byte lanes carry nothing this block stores.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.write_2[31:8], bus.write_enable_2,
                             bus.write_enable_3, bus.write_enable_4};

  // ---------------------------------------------------------------- decode
  assign hit_data   = (bus.addr_2 == DATA_ADDR);
  assign hit_status = (bus.addr_2 == STATUS_ADDR);
  assign bus.sel    = hit_data || hit_status;

  assign fifo_push    = hit_data && bus.write_enable_1;
  assign overflow_set = fifo_push && fifo_full && !fifo_pop;
  assign overflow_clr = hit_status && bus.write_enable_1 && bus.write_2[3];

  // A count of 256 (only possible at the largest depth) does not fit the
  // 8-bit field; the full flag still reports it.
  always_comb begin
    status_word                                  = '0;
    status_word[STAT_FULL]                       = fifo_full;
    status_word[STAT_EMPTY]                      = fifo_empty;
    status_word[STAT_BUSY]                       = (state_reg != ST_IDLE);
    status_word[STAT_OVERFLOW]                   = overflow_reg;
    status_word[STAT_COUNT_LSB +: STAT_COUNT_W]  = STAT_COUNT_W'(fifo_count);
  end

  // DATA reads as zero; only STATUS returns anything.
  assign bus.read_data = hit_status ? status_word : 32'h0;

  // ----------------------------------------------------------------- FIFO
  ad100_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (bus.write_2[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Overflow is sticky; a set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_reg <= 1'b0;
    end else if (overflow_set) begin
      overflow_reg <= 1'b1;
    end else if (overflow_clr) begin
      overflow_reg <= 1'b0;
    end
  end

  // ----------------------------------------------------------- serial FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
    end else begin
      state_reg   <= state_next;
      baud_reg    <= baud_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      tx_reg      <= tx_next;
    end
  end

  // tx_next is the level for the bit that starts on the coming edge, so the
  // line changes on exactly the edge the state does.
  always_comb begin
    state_next   = state_reg;
    baud_next    = baud_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    tx_next      = tx_reg;
    fifo_pop     = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        tx_next = 1'b1;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_next = fifo_dout;
          state_next = ST_START;
          baud_next  = BAUD_LAST;
          tx_next    = 1'b0;
        end
      end

      ST_START: begin
        if (baud_reg == '0) begin
          state_next   = ST_DATA;
          bit_idx_next = 3'd0;
          baud_next    = BAUD_LAST;
          tx_next      = shift_reg[0];
        end else begin
          baud_next = baud_reg - 1'b1;
        end
      end

      ST_DATA: begin
        if (baud_reg == '0) begin
          baud_next = BAUD_LAST;
          if (bit_idx_reg == 3'd7) begin
            state_next = ST_STOP;
            tx_next    = 1'b1;
          end else begin
            shift_next   = {1'b0, shift_reg[7:1]};
            bit_idx_next = bit_idx_reg + 1'b1;
            tx_next      = shift_reg[1];
          end
        end else begin
          baud_next = baud_reg - 1'b1;
        end
      end

      ST_STOP: begin
        if (baud_reg == '0) begin
          if (!fifo_empty) begin
            // Back-to-back frame: no idle bit between stop and next start.
            fifo_pop   = 1'b1;
            shift_next = fifo_dout;
            state_next = ST_START;
            baud_next  = BAUD_LAST;
            tx_next    = 1'b0;
          end else begin
            state_next = ST_IDLE;
            tx_next    = 1'b1;
          end
        end else begin
          baud_next = baud_reg - 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  assign tx = tx_reg;

endmodule

// File: tb/tb_ad100_uart_tx.sv
// tb_ad100_uart_tx: scoreboard bench for ad100_uart_tx (CLKS_PER_BIT=4,
// FIFO_DEPTH=4). The reference model schedules each accepted byte as a
// frame with a start edge (pop edge) and keeps FIFO occupancy as the number
// of scheduled frames not yet started; the monitor decodes tx and compares
// each frame against the expected queue.
module tb_ad100_uart_tx;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * CPB;
  localparam logic [29:0] BASE  = 30'h3FFF_FC00;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx;

  ad100_uart_tx_if bus_if ();

  ad100_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; at the negedge after edge N it is N.
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] data;
    longint     start;
  } frame_t;

  frame_t exp_q[$];
  longint starts[$];
  longint last_start = -1000;
  bit     m_ovf = 1'b0;
  int     reset_epoch = 0;
  bit     mon_busy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ------------------------------------------------------ reference model
  function automatic int occ_before(input longint n);
    int c = 0;
    foreach (starts[i]) if (starts[i] >= n) c++;
    return c;
  endfunction

  function automatic bit pop_at(input longint n);
    foreach (starts[i]) if (starts[i] == n) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int count_after(input longint m);
    int c = 0;
    foreach (starts[i]) if (starts[i] > m) c++;
    return c;
  endfunction

  function automatic bit busy_at(input longint m);
    foreach (starts[i]) if (starts[i] <= m && m < starts[i] + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_status(input longint m);
    int c = count_after(m);
    return {16'h0, 8'(c), 4'h0, m_ovf, busy_at(m), (c == 0), (c == DEPTH)};
  endfunction

  task automatic model_write(input longint n, input logic [29:0] addr,
                             input logic [31:0] data, input logic [3:0] we);
    frame_t f;
    longint s;
    if (addr == BASE && we[0]) begin
      if (occ_before(n) < DEPTH || pop_at(n)) begin
        s = (n + 1 > last_start + FRAME) ? n + 1 : last_start + FRAME;
        starts.push_back(s);
        last_start = s;
        f.data  = data[7:0];
        f.start = s;
        exp_q.push_back(f);
      end else begin
        m_ovf = 1'b1;
      end
    end else if (addr == BASE + 30'd1 && we[0] && data[3]) begin
      m_ovf = 1'b0;
    end
  endtask

  // -------------------------------------------------------------- drivers
  task automatic drive_idle();
    bus_if.addr_2         = '0;
    bus_if.write_2        = '0;
    bus_if.write_enable_1 = 1'b0;
    bus_if.write_enable_2 = 1'b0;
    bus_if.write_enable_3 = 1'b0;
    bus_if.write_enable_4 = 1'b0;
  endtask

  task automatic cpu_write(input logic [29:0] addr, input logic [31:0] data,
                           input logic [3:0] we);
    @(negedge clk);
    bus_if.addr_2         = addr;
    bus_if.write_2        = data;
    bus_if.write_enable_1 = we[0];
    bus_if.write_enable_2 = we[1];
    bus_if.write_enable_3 = we[2];
    bus_if.write_enable_4 = we[3];
    model_write(cyc + 1, addr, data, we);
    $display("write addr=%h data=%h we=%b edge=%0d", addr, data, we, cyc + 1);
    @(posedge clk);
    #1 drive_idle();
  endtask

  task automatic read_status(input string name);
    @(negedge clk);
    bus_if.addr_2         = BASE + 30'd1;
    bus_if.write_enable_1 = 1'b0;
    #1;
    $display("read status=%h cycle=%0d", bus_if.read_data, cyc);
    check(name, bus_if.read_data, exp_status(cyc));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    reset_epoch++;
    exp_q.delete();
    starts.delete();
    last_start = -1000;
    m_ovf = 1'b0;
    $display("reset applied at edge %0d", cyc);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((cyc <= last_start + FRAME || mon_busy || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 3000) begin
      bad++;
      $display("FAIL %s: drain timeout, %0d frames still expected", name, exp_q.size());
    end
  endtask

  // -------------------------------------------------------------- monitor
  initial begin : monitor
    frame_t      e;
    logic [63:0] got;
    logic [63:0] want;
    longint      st;
    int          ep;
    bit          have;
    int          b;
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) begin
        mon_busy = 1'b1;
        st   = cyc;
        ep   = reset_epoch;
        have = (exp_q.size() != 0);
        if (have) e = exp_q.pop_front();
        got    = '0;
        got[0] = tx;
        for (int k = 1; k < FRAME; k++) begin
          @(negedge clk);
          got[k] = tx;
        end
        if (ep == reset_epoch) begin
          if (!have) begin
            total++;
            bad++;
            $display("FAIL frame_unexpected: got frame bits %h at cycle %0d, expected no frame", got, st);
          end else begin
            want = '0;
            for (int k = 0; k < FRAME; k++) begin
              b = k / CPB;
              want[k] = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : e.data[b-1];
            end
            $display("frame start=%0d expected byte=%h expected start=%0d", st, e.data, e.start);
            check("frame_bits", got, want);
            check("frame_start", 64'(st), 64'(e.start));
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------- stimulus
  initial begin : stim
    longint s0;
    logic [29:0] a;
    logic [31:0] exp_rd;
    int op;
    drive_idle();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // 1: reset state, single frame
    @(negedge clk);
    check("reset_tx", tx, 1'b1);
    read_status("reset_status");
    cpu_write(BASE, 32'h0000_00A5, 4'b0001);
    wait_drain("t1_drain");
    read_status("t1_status_after");

    // 2: back-to-back frames
    cpu_write(BASE, 32'h01, 4'b0001);
    cpu_write(BASE, 32'h02, 4'b0001);
    cpu_write(BASE, 32'h03, 4'b0001);
    for (int i = 0; i < 10; i++) begin
      repeat (10) @(negedge clk);
      read_status("t2_status");
    end
    wait_drain("t2_drain");

    // 3: fill, overflow, clear
    cpu_write(BASE, 32'h11, 4'b0001);
    cpu_write(BASE, 32'h22, 4'b0001);
    cpu_write(BASE, 32'h33, 4'b0001);
    cpu_write(BASE, 32'h44, 4'b0001);
    cpu_write(BASE, 32'h55, 4'b0001);
    read_status("t3_full");
    cpu_write(BASE, 32'h66, 4'b0001);
    read_status("t3_overflow");
    cpu_write(BASE + 30'd1, 32'h8, 4'b0001);
    read_status("t3_cleared");
    wait_drain("t3_drain");

    // 4: upper lanes only
    cpu_write(BASE, 32'h5A5A_5A5A, 4'b1110);
    read_status("t4_status");
    repeat (5) @(negedge clk);
    check("t4_tx_idle", tx, 1'b1);

    // 5: reset mid data bit
    cpu_write(BASE, 32'hC3, 4'b0001);
    cpu_write(BASE, 32'h3C, 4'b0001);
    cpu_write(BASE, 32'h96, 4'b0001);
    s0 = starts[0];
    while (cyc < s0 + CPB * 3 + 1) @(negedge clk);
    do_reset();
    @(negedge clk);
    check("t5_tx_after_reset", tx, 1'b1);
    read_status("t5_status");
    repeat (60) @(negedge clk);
    read_status("t5_status_later");
    check("t5_tx_later", tx, 1'b1);

    // 6: address sweep
    for (int i = 0; i < 4; i++) begin
      a = BASE - 30'd1 + 30'(i);
      @(negedge clk);
      bus_if.addr_2         = a;
      bus_if.write_2        = 32'hFF;
      bus_if.write_enable_1 = 1'b1;
      #1;
      exp_rd = (i == 2) ? exp_status(cyc) : 32'h0;
      $display("sweep addr=%h sel=%b read=%h", a, bus_if.sel, bus_if.read_data);
      check("t6_sel", bus_if.sel, (i == 1 || i == 2));
      check("t6_read_data", bus_if.read_data, exp_rd);
      model_write(cyc + 1, a, 32'hFF, 4'b0001);
      @(posedge clk);
      #1 drive_idle();
    end
    wait_drain("t6_drain");
    read_status("t6_status_after");

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 5) begin
        cpu_write(BASE, $urandom(), ($urandom_range(0, 5) == 0) ? 4'($urandom()) : 4'b0001);
      end else if (op <= 7) begin
        read_status("rand_status");
      end else if (op == 8) begin
        cpu_write(BASE + 30'd1, $urandom(), 4'b0001);
      end else begin
        repeat ($urandom_range(0, 50)) @(negedge clk);
      end
    end
    wait_drain("rand_drain");
    read_status("final_status");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
